// File: rtl/core_pkg.sv
// Shared types and constants for the Risc-Inci core front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package core_pkg;

    localparam int cXLEN         = 32;
    localparam int cInstMemDepth = 1024;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } tFetchState;

endpackage

// File: rtl/inst_fetch_mem.sv
// Instruction RAM: simple dual-port, one write port and one enabled sync read port.
// Latency: 1 cycle from re to rdata; rdata holds while re=0.
// Backpressure: none; the caller stalls by deasserting re.
// Ports: clk/rst, we/waddr/wdata write port, re/raddr read port, rdata output register (sync reset to 0).
module inst_mem
    import core_pkg::*;
#(
    parameter int XLEN  = cXLEN,
    parameter int DEPTH = cInstMemDepth
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [XLEN-1:0]          wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [XLEN-1:0]          rdata
);

    logic [XLEN-1:0] mem [DEPTH];
    logic [XLEN-1:0] rdata_q;

    // Array has no reset so its contents survive a core reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read kept inside the clocked block so the array maps onto block RAM
    // with its output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: loads the program into instruction RAM, then streams instr+PC to decode.
// Latency: 2 cycles from i_start to first o_valid; 1 instr/cycle steady state.
// Backpressure: i_stall holds PC, RAM read and all outputs; i_br_taken overrides it.
// Ports: clk/rst; i_inst_wdata/i_inst_wen load stream; i_start; i_stall; i_br_taken/i_br_target;
//        o_instr/o_pc/o_valid to decode; o_load_full; o_done.
// Option: FETCH_MISALIGN_TRAP_EN adds o_misalign and halts on a redirect with target[1:0]!=0;
//         without it the low two target bits are forced to zero.
module inst_fetch
    import core_pkg::*;
#(
    parameter int              XLEN      = cXLEN,
    parameter int              MEM_DEPTH = cInstMemDepth,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] i_inst_wdata,
    input  logic            i_inst_wen,
    input  logic            i_start,
    input  logic            i_stall,
    input  logic            i_br_taken,
    input  logic [XLEN-1:0] i_br_target,
    output logic [XLEN-1:0] o_instr,
    output logic [XLEN-1:0] o_pc,
    output logic            o_valid,
    output logic            o_load_full,
    output logic            o_done
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            o_misalign
`endif
);

    localparam int AW = $clog2(MEM_DEPTH);

    tFetchState      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] opc_q, opc_d;
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic            valid_q, valid_d;
    logic            load_full_q, load_full_d;
    logic            done_q, done_d;
    logic            mem_we, mem_re;
    logic [XLEN-1:0] prog_bytes;
    logic [XLEN-1:0] br_tgt;
    logic            br_misalign;
    logic            br_bad;

    // Program occupies [RESET_PC, RESET_PC + prog_bytes). Range checks use the
    // offset from RESET_PC so an address below RESET_PC wraps large and fails.
    assign prog_bytes = XLEN'(wr_ptr_q) << 2;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    assign br_tgt      = i_br_target;
    assign br_misalign = |i_br_target[1:0];
    assign o_misalign  = misalign_q;
`else
    logic unused_br_lsb;
    assign br_tgt        = {i_br_target[XLEN-1:2], 2'b00};
    assign br_misalign   = 1'b0;
    assign unused_br_lsb = ^i_br_target[1:0];
`endif

    assign br_bad = br_misalign || ((br_tgt - RESET_PC) >= prog_bytes);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        opc_d       = opc_q;
        wr_ptr_d    = wr_ptr_q;
        valid_d     = valid_q;
        load_full_d = load_full_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign_d  = misalign_q;
`endif
        unique case (state_q)
            IDLE: begin
                // wr_ptr_q[AW] set means the RAM is full; extra words are dropped.
                if (i_inst_wen && !wr_ptr_q[AW]) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + (AW+1)'(1);
                end
                load_full_d = wr_ptr_d[AW];
                // Use the post-write count so a word loaded alongside i_start is included.
                if (i_start) begin
                    state_d = (wr_ptr_d != '0) ? RUN : HALT;
                end
            end
            RUN: begin
                if (i_br_taken) begin
                    // Squash the fetch in flight; target is issued next cycle.
                    valid_d = 1'b0;
                    pc_d    = br_tgt;
                    if (br_bad) begin
                        state_d = HALT;
                    end
`ifdef FETCH_MISALIGN_TRAP_EN
                    misalign_d = misalign_q | br_misalign;
`endif
                end else if (!i_stall) begin
                    if ((pc_q - RESET_PC) < prog_bytes) begin
                        mem_re  = 1'b1;
                        opc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + XLEN'(4);
                    end else begin
                        // Output already shown was consumed this cycle.
                        state_d = HALT;
                        valid_d = 1'b0;
                    end
                end
            end
            HALT: begin
                if (!i_stall) begin
                    valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            opc_q       <= '0;
            wr_ptr_q    <= '0;
            valid_q     <= 1'b0;
            load_full_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            opc_q       <= opc_d;
            wr_ptr_q    <= wr_ptr_d;
            valid_q     <= valid_d;
            load_full_q <= load_full_d;
            done_q      <= done_d;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end
`endif

    inst_mem #(
        .XLEN  (XLEN),
        .DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .waddr (wr_ptr_q[AW-1:0]),
        .wdata (i_inst_wdata),
        .re    (mem_re),
        .raddr (pc_q[AW+1:2]),
        .rdata (o_instr)
    );

    assign o_pc        = opc_q;
    assign o_valid     = valid_q;
    assign o_load_full = load_full_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: scoreboard of expected (pc, instr) plus timing checks.
// Latency: n/a.
// Backpressure: exercises i_stall and i_br_taken.
module tb_inst_fetch;

    localparam int XLEN  = 32;
    localparam int DEPTH = 1024;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [XLEN-1:0] i_inst_wdata = '0;
    logic            i_inst_wen = 1'b0;
    logic            i_start = 1'b0;
    logic            i_stall = 1'b0;
    logic            i_br_taken = 1'b0;
    logic [XLEN-1:0] i_br_target = '0;
    logic [XLEN-1:0] o_instr;
    logic [XLEN-1:0] o_pc;
    logic            o_valid;
    logic            o_load_full;
    logic            o_done;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            o_misalign;
`endif

    always #5 clk = ~clk;

    inst_fetch #(
        .XLEN      (XLEN),
        .MEM_DEPTH (DEPTH),
        .RESET_PC  (32'h0)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .i_inst_wdata (i_inst_wdata),
        .i_inst_wen   (i_inst_wen),
        .i_start      (i_start),
        .i_stall      (i_stall),
        .i_br_taken   (i_br_taken),
        .i_br_target  (i_br_target),
        .o_instr      (o_instr),
        .o_pc         (o_pc),
        .o_valid      (o_valid),
        .o_load_full  (o_load_full),
        .o_done       (o_done)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .o_misalign   (o_misalign)
`endif
    );

    int              vectors = 0;
    int              miscompares = 0;
    logic [XLEN-1:0] prog [DEPTH+2];
    int              sb_q [$];
    int              mon_idx;

    task automatic check_vec(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Decode consumes an instruction on every non-stalled cycle with o_valid.
    always @(negedge clk) begin
        if (!rst && o_valid === 1'b1 && !i_stall) begin
            if (sb_q.size() == 0) begin
                check_vec("extra_issue", o_valid, 1'b0);
            end else begin
                mon_idx = sb_q.pop_front();
                check_vec("issue_pc", o_pc, XLEN'(mon_idx * 4));
                check_vec("issue_instr", o_instr, prog[mon_idx]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst        = 1'b1;
        i_start    = 1'b0;
        i_stall    = 1'b0;
        i_br_taken = 1'b0;
        i_inst_wen = 1'b0;
        sb_q.delete();
        step();
        check_vec({tag, "_rst_valid"}, o_valid, 1'b0);
        check_vec({tag, "_rst_pc"}, o_pc, '0);
        check_vec({tag, "_rst_instr"}, o_instr, '0);
        check_vec({tag, "_rst_done"}, o_done, 1'b0);
        check_vec({tag, "_rst_full"}, o_load_full, 1'b0);
        rst = 1'b0;
    endtask

    task automatic load(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            i_inst_wen   = 1'b1;
            i_inst_wdata = prog[first + i];
            step();
        end
        i_inst_wen = 1'b0;
    endtask

    task automatic push_range(input int first, input int n);
        for (int i = 0; i < n; i++) sb_q.push_back(first + i);
    endtask

    task automatic wait_pc(input string tag, input logic [XLEN-1:0] pc, input int budget);
        bit found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (o_valid === 1'b1 && o_pc === pc) begin
                found = 1'b1;
                break;
            end
            step();
        end
        if (!found) check_vec({tag, "_wait_pc"}, o_pc, pc);
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && o_done !== 1'b1; i++) step();
        check_vec({tag, "_done"}, o_done, 1'b1);
        check_vec({tag, "_done_valid"}, o_valid, 1'b0);
        check_vec({tag, "_drain"}, sb_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < DEPTH + 2; i++) prog[i] = $urandom;

        // 4 words, the last one loaded in the same cycle as i_start.
        do_reset("t1");
        load(0, 3);
        i_inst_wen   = 1'b1;
        i_inst_wdata = prog[3];
        i_start      = 1'b1;
        push_range(0, 4);
        step();
        i_inst_wen = 1'b0;
        check_vec("t1_gap_t1", o_valid, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_vec("t1_stream_valid", o_valid, 1'b1);
            check_vec("t1_stream_pc", o_pc, XLEN'(i * 4));
        end
        step();
        check_vec("t1_halt_valid", o_valid, 1'b0);
        check_vec("t1_halt_done", o_done, 1'b1);
        // Redirect in HALT is ignored.
        i_br_taken  = 1'b1;
        i_br_target = 32'h0;
        step();
        i_br_taken = 1'b0;
        step();
        check_vec("t1_halt_br_valid", o_valid, 1'b0);
        check_vec("t1_halt_br_done", o_done, 1'b1);
        check_vec("t1_drain", sb_q.size(), 0);

        // Stall for 3 cycles while 0x8 is presented.
        do_reset("t2");
        load(0, 8);
        i_start = 1'b1;
        push_range(0, 8);
        wait_pc("t2", 32'h8, 20);
        i_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            if (k == 2) i_stall = 1'b0;
            check_vec("t2_hold_valid", o_valid, 1'b1);
            check_vec("t2_hold_pc", o_pc, 32'h8);
            check_vec("t2_hold_instr", o_instr, prog[2]);
        end
        step();
        check_vec("t2_resume_valid", o_valid, 1'b1);
        check_vec("t2_resume_pc", o_pc, 32'hC);
        wait_done("t2", 30);

        // Redirect to 0x14 while 0x8 is presented.
        do_reset("t3");
        load(0, 8);
        i_start = 1'b1;
        sb_q.push_back(0);
        sb_q.push_back(1);
        sb_q.push_back(2);
        push_range(5, 3);
        wait_pc("t3", 32'h8, 20);
        i_br_taken  = 1'b1;
        i_br_target = 32'h14;
        step();
        i_br_taken = 1'b0;
        check_vec("t3_squash_valid", o_valid, 1'b0);
        step();
        check_vec("t3_target_valid", o_valid, 1'b1);
        check_vec("t3_target_pc", o_pc, 32'h14);
        check_vec("t3_target_instr", o_instr, prog[5]);
        wait_done("t3", 30);

        // Empty program: straight to HALT.
        do_reset("t4");
        i_start = 1'b1;
        step();
        check_vec("t4_done", o_done, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            check_vec("t4_no_valid", o_valid, 1'b0);
        end

        // Overfill the memory by two words.
        do_reset("t5");
        load(0, DEPTH - 1);
        check_vec("t5_not_full", o_load_full, 1'b0);
        load(DEPTH - 1, 1);
        check_vec("t5_full", o_load_full, 1'b1);
        load(DEPTH, 2);
        check_vec("t5_still_full", o_load_full, 1'b1);
        i_start = 1'b1;
        push_range(0, DEPTH);
        wait_done("t5", DEPTH + 20);

        // Reset in the middle of a run (do_reset checks reset values).
        do_reset("t6a");
        load(0, 8);
        i_start = 1'b1;
        push_range(0, 8);
        wait_pc("t6", 32'h10, 20);
        do_reset("t6b");

        // Misaligned redirect to 0x6 while 0x0 is presented.
        do_reset("t7");
        load(0, 4);
        i_start = 1'b1;
        sb_q.push_back(0);
`ifndef FETCH_MISALIGN_TRAP_EN
        push_range(1, 3);
`endif
        wait_pc("t7", 32'h0, 20);
        i_br_taken  = 1'b1;
        i_br_target = 32'h6;
        step();
        i_br_taken = 1'b0;
        check_vec("t7_squash_valid", o_valid, 1'b0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_vec("t7_misalign", o_misalign, 1'b1);
        step();
        check_vec("t7_trap_done", o_done, 1'b1);
        check_vec("t7_trap_valid", o_valid, 1'b0);
        check_vec("t7_misalign_hold", o_misalign, 1'b1);
        check_vec("t7_drain", sb_q.size(), 0);
`else
        step();
        check_vec("t7_align_valid", o_valid, 1'b1);
        check_vec("t7_align_pc", o_pc, 32'h4);
        check_vec("t7_align_instr", o_instr, prog[1]);
        wait_done("t7", 30);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
